// File: rtl/bsg_mcl_rcv_serializer.sv
// Receive-path packet FIFO that serializes the head packet into host words, LSW first,
// and reports free packet slots plus a low-vacancy flag for endpoint flow control.
module bsg_mcl_rcv_serializer #(
    parameter int fifo_width_p = 128,
    parameter int word_width_p = 32,
    parameter int els_p        = 4,
    parameter int threshold_p  = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [fifo_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [word_width_p-1:0] data_o,
    input  logic                    yumi_i,
    output logic [31:0]             vacancy_o,
    output logic                    th_o
);
    localparam int words_lp      = fifo_width_p / word_width_p;
    localparam int cnt_width_lp  = $clog2(els_p + 1);
    localparam int ptr_width_lp  = $clog2(els_p);
    localparam int widx_width_lp = $clog2(words_lp);

    localparam logic [ptr_width_lp-1:0]  ptr_max_lp  = ptr_width_lp'(els_p - 1);
    localparam logic [widx_width_lp-1:0] widx_max_lp = widx_width_lp'(words_lp - 1);
    localparam logic [cnt_width_lp-1:0]  els_lp      = cnt_width_lp'(els_p);
    localparam logic [cnt_width_lp-1:0]  th_lp       = cnt_width_lp'(threshold_p);

    logic [fifo_width_p-1:0]  mem [els_p];
    logic [ptr_width_lp-1:0]  wptr, rptr;
    logic [cnt_width_lp-1:0]  occ, vac;
    logic [widx_width_lp-1:0] widx;
    logic [fifo_width_p-1:0]  head;
    logic                     enq, yumi_v, last_yumi;

    assign ready_o   = (occ < els_lp);
    assign v_o       = (occ != '0);
    assign enq       = v_i & ready_o;
    // An illegal yumi on an empty FIFO is masked so state stays put.
    assign yumi_v    = yumi_i & v_o;
    assign last_yumi = yumi_v & (widx == widx_max_lp);

    assign vac       = els_lp - occ;
    assign vacancy_o = 32'(vac);
    assign th_o      = (vac < th_lp);

    assign head      = mem[rptr];
    assign data_o    = head[widx*word_width_p +: word_width_p];

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            widx <= '0;
        end else begin
            if (enq) begin
                wptr <= (wptr == ptr_max_lp) ? '0 : wptr + 1'b1;
            end
            if (last_yumi) begin
                rptr <= (rptr == ptr_max_lp) ? '0 : rptr + 1'b1;
                widx <= '0;
            end else if (yumi_v) begin
                widx <= widx + 1'b1;
            end
            case ({enq, last_yumi})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
        else $error("yumi_i asserted while v_o is low");

endmodule

// File: doc/bsg_mcl_rcv_serializer.md
# bsg_mcl_rcv_serializer

Manycore-to-host receive path stage. It sits between the manycore endpoint-to-FIFO adapter's outgoing packet port and the AXI-Lite FIFO front end. It buffers whole `fifo_width_p`-bit packets in an `els_p`-deep FIFO and serializes the head packet into `word_width_p`-bit words for host reads. It also exports a packet-slot vacancy count and a threshold flag, which the endpoint uses for flow control.

## Interface

**Parameters**
- `fifo_width_p`, 128, packet width; must be an integer multiple of `word_width_p`.
- `word_width_p`, 32, host word width.
- `els_p`, 4, packet FIFO depth; must be ≥ 2.
- `threshold_p`, 2, `th_o` asserts when vacancy < `threshold_p`; range 1..`els_p`.
- Derived: `words_lp` = `fifo_width_p`/`word_width_p` (≥ 2); `cnt_width_lp` = clog2(`els_p`+1).

**Ports**
- `clk_i`, input, 1: the single clock.
- `reset_i`, input, 1: asynchronous, active-high reset.
- `v_i`, input, 1: packet valid from the endpoint side.
- `data_i`, input, `fifo_width_p`: packet.
- `ready_o`, output, 1: a slot is free. Depends only on state, never on `v_i`.
- `v_o`, output, 1: host word valid.
- `data_o`, output, `word_width_p`: current word of the head packet.
- `yumi_i`, input, 1: host consumes the word. Legal only when `v_o`=1.
- `vacancy_o`, output, 32: free packet slots, zero-extended.
- `th_o`, output, 1: `vacancy_o` < `threshold_p`.

## Operation

- Input handshake is ready/valid: a packet is enqueued when `v_i & ready_o`.
- Output handshake is valid/yumi: a word is consumed when `yumi_i`.
- Storage:
  - `els_p`-entry circular buffer with read and write pointers that wrap modulo `els_p`.
  - Occupancy counter of `cnt_width_lp` bits, range 0..`els_p`.
  - Word index `widx` of clog2(`words_lp`) bits.
- Serialization order:
  - `data_o` = `head[widx*word_width_p +: word_width_p]`, least-significant word first.
  - `widx` increments on each `yumi_i`.
  - On `yumi_i` with `widx` = `words_lp`-1: `widx` returns to 0 and the head packet is dequeued. This is the "last-word yumi".
- Vacancy:
  - `vacancy_o` = `els_p` − occupancy.
  - A packet counts as occupied until its last word is consumed; a partially read packet still holds its slot.
- Output conditions:
  - `ready_o` = occupancy < `els_p`.
  - `v_o` = occupancy > 0.
- Simultaneous enqueue and last-word yumi: occupancy is unchanged, and both pointers advance.
- Full FIFO: `ready_o`=0 even if a last-word yumi occurs that cycle. There is no same-cycle bypass.
- Empty FIFO: `v_o`=0. An enqueue into an empty FIFO is not visible on `v_o` until the next cycle (no fall-through).
- Stability: `data_o` holds stable while `v_o & ~yumi_i`. Contents written into non-head entries never disturb the head.
- Arithmetic: all counters are unsigned. Occupancy never exceeds `els_p` and never goes below 0.
- Illegal input: `yumi_i` while `v_o`=0 fires a simulation assertion (error), and state is unchanged.

## Timing

- Reset (asynchronous assert, release synchronous to `clk_i`):
  - Occupancy=0, pointers=0, `widx`=0.
  - `ready_o`=1, `v_o`=0, `vacancy_o`=`els_p`, `th_o`=0.
  - `data_o` is don't-care.
- Reset mid-packet discards all buffered and partially read packets. No words are emitted after reset until a new enqueue.
- Latency: packet accepted at edge t gives `v_o`=1 with word 0 in the cycle after t. The minimum total packet drain is `words_lp` cycles with `yumi_i` held high.
- Throughput: one word per cycle on the output, and one packet per cycle on the input while not full.
- `vacancy_o` and `th_o` are combinational from registered occupancy. They update in the cycle after the enqueue or dequeue edge.
- Packet storage is registers. `data_o` is a mux of registered state with no combinational path from any input.

## Test plan

- **Reset values.** Assert `reset_i` asynchronously mid-cycle → `ready_o`=1, `v_o`=0, `vacancy_o`=4, `th_o`=0 immediately, without waiting for a clock edge.
- **Single packet.** Enqueue `data_i`=0x44444444_33333333_22222222_11111111, then hold `yumi_i`=1 → `data_o` reads 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles. `vacancy_o` reads 3 during the drain and 4 after the last word.
- **Fill to full.** Enqueue 4 packets with no yumi → `ready_o`=0, `vacancy_o`=0, `th_o`=1. A 5th `v_i` is not accepted. A last-word yumi with `v_i`=1 in the same cycle still gives `ready_o`=0 that cycle; the next cycle gives `ready_o`=1.
- **Simultaneous events.** With occupancy 2, enqueue a packet in the same cycle as a last-word yumi → occupancy stays 2, and the next head word is word 0 of the second packet.
- **Partial read holds slot.** Consume 2 of 4 words → `vacancy_o` is unchanged. Then pulse reset → `vacancy_o`=4, `v_o`=0. A following enqueue of 0xA…D emits word 0 first.
- **Random soak.** Random `v_i` and `yumi_i` over 10k cycles against a scoreboard → all words match in order, `vacancy_o` equals `els_p` − occupancy every cycle, and the illegal-yumi assertion never fires.
